wb_master_port: RTL and testbench

Single-outstanding Wishbone classic-cycle initiator that converts a core-side valid/ready request into one bus read or write and returns one response. It sits between the CPU fetch/load-store path and the big-endian Wishbone interconnect that hosts flash, RAM and peripherals. The block also handles byte-lane swapping, retry on `rty_i`, and a bus timeout.

---
 rtl/wb_pkg.sv | 48 ++++
 rtl/wb_byte_lane_swap.sv | 15 +
 rtl/wb_master_port.sv | 174 +++++++++++++++++
 tb/tb_wb_master_port.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and helpers for the Wishbone initiator: FSM states, termination
// kinds with their priority order, and big-endian byte-lane swap functions.
package wb_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUS,
    S_BACKOFF,
    S_RESP
  } wb_master_state_t;

  typedef enum logic [1:0] {
    TERM_NONE,
    TERM_ACK,
    TERM_RTY,
    TERM_ERR
  } wb_term_t;

  // Lowest priority in the bottom slot, highest in the top slot.
  localparam logic [5:0] WB_TERM_PRIO = {TERM_ERR, TERM_RTY, TERM_ACK};

  function automatic logic [31:0] wb_swap32(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  function automatic logic [3:0] wb_swap_sel(input logic [3:0] s);
    return {s[0], s[1], s[2], s[3]};
  endfunction

  function automatic wb_term_t wb_resolve_term(input logic err, input logic rty, input logic ack);
    wb_term_t res;
    wb_term_t kind;
    logic     hit;
    res = TERM_NONE;
    for (int i = 0; i < 3; i++) begin
      kind = wb_term_t'(WB_TERM_PRIO[2*i +: 2]);
      case (kind)
        TERM_ERR: hit = err;
        TERM_RTY: hit = rty;
        TERM_ACK: hit = ack;
        default:  hit = 1'b0;
      endcase
      if (hit) res = kind;
    end
    return res;
  endfunction

endpackage

// File: rtl/wb_byte_lane_swap.sv
// Combinational core <-> big-endian bus lane swap for 32-bit data and 4-bit select.
// Zero latency, no flow control; used on both the write and the read paths.
module wb_byte_lane_swap
  import wb_pkg::*;
(
  input  logic [31:0] dat_i,
  input  logic [3:0]  sel_i,
  output logic [31:0] dat_o,
  output logic [3:0]  sel_o
);

  assign dat_o = wb_swap32(dat_i);
  assign sel_o = wb_swap_sel(sel_i);

endmodule

// File: rtl/wb_master_port.sv
// Single-outstanding Wishbone classic initiator with retry, timeout and lane swap.
// Ready only in IDLE (one transaction per >=4 cycles); response is a 1-cycle pulse, no backpressure.
module wb_master_port
  import wb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned MAX_RETRIES    = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_addr_i,
  input  logic        req_we_i,
  input  logic [3:0]  req_be_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        rsp_timeout_o,
  output logic        cyc_o,
  output logic        stb_o,
  output logic [31:0] adr_o,
  output logic [3:0]  sel_o,
  output logic [31:0] dat_o,
  output logic        we_o,
  input  logic [31:0] dat_i,
  input  logic        ack_i,
  input  logic        err_i,
  input  logic        rty_i
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RW = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

  wb_master_state_t state_q;
  logic [TW-1:0]    timer_q;
  logic [RW-1:0]    retries_q;
  logic             req_ready_q;
  logic             cyc_q;
  logic             we_q;
  logic [31:0]      adr_q;
  logic [3:0]       sel_q;
  logic [31:0]      dat_q;
  logic             rsp_valid_q;
  logic [31:0]      rsp_rdata_q;
  logic             rsp_err_q;
  logic             rsp_timeout_q;

  logic [31:0] wr_dat_d;
  logic [3:0]  wr_sel_d;
  logic [31:0] rd_dat_d;
  logic [3:0]  rd_sel_unused;
  wb_term_t    term_d;

  wb_byte_lane_swap u_wr_swap (
    .dat_i (req_wdata_i),
    .sel_i (req_be_i),
    .dat_o (wr_dat_d),
    .sel_o (wr_sel_d)
  );

  wb_byte_lane_swap u_rd_swap (
    .dat_i (dat_i),
    .sel_i (sel_q),
    .dat_o (rd_dat_d),
    .sel_o (rd_sel_unused)
  );

  assign term_d = wb_resolve_term(err_i, rty_i, ack_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      timer_q       <= '0;
      retries_q     <= '0;
      req_ready_q   <= 1'b1;
      cyc_q         <= 1'b0;
      we_q          <= 1'b0;
      adr_q         <= '0;
      sel_q         <= '0;
      dat_q         <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            adr_q       <= req_addr_i;
            we_q        <= req_we_i;
            sel_q       <= wr_sel_d;
            dat_q       <= wr_dat_d;
            retries_q   <= '0;
            timer_q     <= '0;
            cyc_q       <= 1'b1;
            req_ready_q <= 1'b0;
            state_q     <= S_BUS;
          end
        end
        S_BUS: begin
          timer_q <= timer_q + TW'(1);
          // Terminations are checked before the timeout so a late answer still wins.
          case (term_d)
            TERM_ERR: begin
              cyc_q       <= 1'b0;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
              state_q     <= S_RESP;
            end
            TERM_RTY: begin
              cyc_q <= 1'b0;
              if (retries_q < RW'(MAX_RETRIES)) begin
                retries_q <= retries_q + RW'(1);
                state_q   <= S_BACKOFF;
              end else begin
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= 1'b1;
                rsp_rdata_q <= '0;
                state_q     <= S_RESP;
              end
            end
            TERM_ACK: begin
              cyc_q       <= 1'b0;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b0;
              rsp_rdata_q <= we_q ? 32'h0 : rd_dat_d;
              state_q     <= S_RESP;
            end
            default: begin
              if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                cyc_q         <= 1'b0;
                rsp_valid_q   <= 1'b1;
                rsp_err_q     <= 1'b1;
                rsp_timeout_q <= 1'b1;
                rsp_rdata_q   <= '0;
                state_q       <= S_RESP;
              end
            end
          endcase
        end
        S_BACKOFF: begin
          timer_q <= '0;
          cyc_q   <= 1'b1;
          state_q <= S_BUS;
        end
        S_RESP: begin
          rsp_err_q     <= 1'b0;
          rsp_timeout_q <= 1'b0;
          rsp_rdata_q   <= '0;
          req_ready_q   <= 1'b1;
          state_q       <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready_o   = req_ready_q;
  assign cyc_o         = cyc_q;
  assign stb_o         = cyc_q;
  assign adr_o         = adr_q;
  assign we_o          = we_q;
  assign sel_o         = sel_q;
  assign dat_o         = dat_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_rdata_o   = rsp_rdata_q;
  assign rsp_err_o     = rsp_err_q;
  assign rsp_timeout_o = rsp_timeout_q;

endmodule

// File: tb/tb_wb_master_port.sv
// Directed bench: one port with MAX_RETRIES=3 and one with MAX_RETRIES=1 share stimulus
// and a registered-ack responder; both use TIMEOUT_CYCLES=8.
module tb_wb_master_port;

  localparam int M_ACK    = 0;
  localparam int M_RTY    = 1;
  localparam int M_ERRACK = 2;
  localparam int M_SILENT = 3;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic [31:0] req_addr_i = '0;
  logic        req_we_i = 1'b0;
  logic [3:0]  req_be_i = '0;
  logic [31:0] req_wdata_i = '0;
  logic [31:0] dat_i = 32'h1122_3344;
  logic        ack_i = 1'b0;
  logic        err_i = 1'b0;
  logic        rty_i = 1'b0;

  logic        req_ready_o, rsp_valid_o, rsp_err_o, rsp_timeout_o;
  logic [31:0] rsp_rdata_o, adr_o, dat_o;
  logic [3:0]  sel_o;
  logic        cyc_o, stb_o, we_o;

  logic        b_req_ready_o, b_rsp_valid_o, b_rsp_err_o, b_rsp_timeout_o;
  logic [31:0] b_rsp_rdata_o, b_adr_unused, b_dat_unused;
  logic [3:0]  b_sel_unused;
  logic        b_cyc_o, b_stb_unused, b_we_unused;

  always #5 clk_i = ~clk_i;

  wb_master_port #(.TIMEOUT_CYCLES(8), .MAX_RETRIES(3)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .req_we_i(req_we_i), .req_be_i(req_be_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .rsp_timeout_o(rsp_timeout_o), .cyc_o(cyc_o), .stb_o(stb_o), .adr_o(adr_o),
    .sel_o(sel_o), .dat_o(dat_o), .we_o(we_o), .dat_i(dat_i), .ack_i(ack_i),
    .err_i(err_i), .rty_i(rty_i)
  );

  wb_master_port #(.TIMEOUT_CYCLES(8), .MAX_RETRIES(1)) dut_r1 (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(b_req_ready_o), .req_addr_i(req_addr_i),
    .req_we_i(req_we_i), .req_be_i(req_be_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(b_rsp_valid_o), .rsp_rdata_o(b_rsp_rdata_o), .rsp_err_o(b_rsp_err_o),
    .rsp_timeout_o(b_rsp_timeout_o), .cyc_o(b_cyc_o), .stb_o(b_stb_unused), .adr_o(b_adr_unused),
    .sel_o(b_sel_unused), .dat_o(b_dat_unused), .we_o(b_we_unused), .dat_i(dat_i), .ack_i(ack_i),
    .err_i(err_i), .rty_i(rty_i)
  );

  // Registered responder following the MAX_RETRIES=3 port's cycle.
  int   mode = M_ACK;
  int   rty_budget = 0;
  int   rty_done = 0;
  logic c_s, had_s;

  always @(posedge clk_i) begin
    c_s   = cyc_o;
    had_s = ack_i | err_i | rty_i;
    if (req_valid_i && req_ready_o) rty_done = 0;
    #1;
    ack_i = 1'b0;
    err_i = 1'b0;
    rty_i = 1'b0;
    if (c_s && !had_s && !rst_i) begin
      case (mode)
        M_ACK: ack_i = 1'b1;
        M_RTY: begin
          if (rty_done < rty_budget) begin
            rty_i = 1'b1;
            rty_done++;
          end else begin
            ack_i = 1'b1;
          end
        end
        M_ERRACK: begin
          err_i = 1'b1;
          ack_i = 1'b1;
        end
        default: ;
      endcase
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  int          lat, cyc_hi, rises, stb_diff, b_lat, b_n;
  logic [31:0] rd, b_rd, bus_adr, bus_dat;
  logic [3:0]  bus_sel;
  logic        er, to, b_er, b_to, bus_we, post_ready, post_vld;

  task automatic issue(input logic [31:0] a, input logic w, input logic [3:0] be, input logic [31:0] wd);
    for (int i = 0; i < 32 && req_ready_o !== 1'b1; i++) @(negedge clk_i);
    req_addr_i  = a;
    req_we_i    = w;
    req_be_i    = be;
    req_wdata_i = wd;
    req_valid_i = 1'b1;
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
  endtask

  // k counts cycles after the accepting edge; stops at the first response of the 3-retry port.
  task automatic await_rsp();
    logic prev;
    prev = 1'b0;
    lat = -1; cyc_hi = 0; rises = 0; stb_diff = 0; b_lat = -1; b_n = 0;
    for (int k = 1; k <= 64 && lat < 0; k++) begin
      @(negedge clk_i);
      if (k == 1) begin
        bus_adr = adr_o; bus_dat = dat_o; bus_sel = sel_o; bus_we = we_o;
      end
      if (cyc_o) cyc_hi++;
      if (cyc_o && !prev) rises++;
      prev = cyc_o;
      if (cyc_o !== stb_o) stb_diff++;
      if (b_rsp_valid_o) begin
        b_n++; b_lat = k; b_er = b_rsp_err_o; b_rd = b_rsp_rdata_o; b_to = b_rsp_timeout_o;
      end
      if (rsp_valid_o) begin
        lat = k; rd = rsp_rdata_o; er = rsp_err_o; to = rsp_timeout_o;
      end
    end
    @(negedge clk_i);
    post_ready = req_ready_o;
    post_vld   = rsp_valid_o;
  endtask

  initial begin
    int n_rsp;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_ready", 32'(req_ready_o), 32'h1);
    check("rst_cyc", 32'(cyc_o), 32'h0);
    check("rst_stb", 32'(stb_o), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid_o), 32'h0);
    check("rst_adr", adr_o, 32'h0);
    check("rst_sel", 32'(sel_o), 32'h0);
    check("rst_dat", dat_o, 32'h0);
    check("rst_we", 32'(we_o), 32'h0);
    check("rst_b_ready", 32'(b_req_ready_o), 32'h1);
    check("rst_b_cyc", 32'(b_cyc_o), 32'h0);
    rst_i = 1'b0;

    // Nominal read
    mode = M_ACK;
    issue(32'h0000_0004, 1'b0, 4'hF, 32'h0);
    await_rsp();
    check("rd_lat", 32'(lat), 32'd3);
    check("rd_rdata", rd, 32'h4433_2211);
    check("rd_err", 32'(er), 32'h0);
    check("rd_timeout", 32'(to), 32'h0);
    check("rd_adr", bus_adr, 32'h0000_0004);
    check("rd_we", 32'(bus_we), 32'h0);
    check("rd_sel", 32'(bus_sel), 32'hF);
    check("rd_cyc_hi", 32'(cyc_hi), 32'd2);
    check("rd_stb_eq_cyc", 32'(stb_diff), 32'd0);
    check("rd_ready_c4", 32'(post_ready), 32'h1);
    check("rd_single_pulse", 32'(post_vld), 32'h0);

    // Write with partial byte enables
    issue(32'h0000_0100, 1'b1, 4'b0011, 32'hAABB_CCDD);
    await_rsp();
    check("wr_sel", 32'(bus_sel), 32'hC);
    check("wr_dat", bus_dat, 32'hDDCC_BBAA);
    check("wr_we", 32'(bus_we), 32'h1);
    check("wr_adr", bus_adr, 32'h0000_0100);
    check("wr_lat", 32'(lat), 32'd3);
    check("wr_err", 32'(er), 32'h0);
    check("wr_rdata", rd, 32'h0);

    // Two retries then ack; the 1-retry port gives up on the second rty
    mode = M_RTY;
    rty_budget = 2;
    issue(32'h0000_0008, 1'b0, 4'hF, 32'h0);
    await_rsp();
    check("rty_lat", 32'(lat), 32'd9);
    check("rty_phases", 32'(rises), 32'd3);
    check("rty_cyc_hi", 32'(cyc_hi), 32'd6);
    check("rty_err", 32'(er), 32'h0);
    check("rty_rdata", rd, 32'h4433_2211);
    check("rty_single_pulse", 32'(post_vld), 32'h0);
    check("rty1_count", 32'(b_n), 32'd1);
    check("rty1_lat", 32'(b_lat), 32'd6);
    check("rty1_err", 32'(b_er), 32'h1);
    check("rty1_rdata", b_rd, 32'h0);

    // err and ack together
    mode = M_ERRACK;
    issue(32'h0000_000C, 1'b0, 4'hF, 32'h0);
    await_rsp();
    check("prio_lat", 32'(lat), 32'd3);
    check("prio_err", 32'(er), 32'h1);
    check("prio_rdata", rd, 32'h0);
    check("prio_timeout", 32'(to), 32'h0);

    // Silent responder
    mode = M_SILENT;
    issue(32'h0000_0010, 1'b0, 4'hF, 32'h0);
    await_rsp();
    check("to_cyc_hi", 32'(cyc_hi), 32'd8);
    check("to_phases", 32'(rises), 32'd1);
    check("to_lat", 32'(lat), 32'd9);
    check("to_err", 32'(er), 32'h1);
    check("to_flag", 32'(to), 32'h1);
    check("to_r1_lat", 32'(b_lat), 32'd9);
    check("to_r1_flag", 32'(b_to), 32'h1);

    // Reset pulsed in the first BUS cycle
    issue(32'h0000_0014, 1'b0, 4'hF, 32'h0);
    @(negedge clk_i);
    check("mid_rst_cyc_before", 32'(cyc_o), 32'h1);
    rst_i = 1'b1;
    @(negedge clk_i);
    check("mid_rst_cyc_after", 32'(cyc_o), 32'h0);
    check("mid_rst_ready", 32'(req_ready_o), 32'h1);
    rst_i = 1'b0;
    n_rsp = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_i);
      if (rsp_valid_o || b_rsp_valid_o) n_rsp++;
    end
    check("mid_rst_no_rsp", 32'(n_rsp), 32'd0);

    mode = M_ACK;
    issue(32'h0000_0004, 1'b0, 4'hF, 32'h0);
    await_rsp();
    check("post_rst_lat", 32'(lat), 32'd3);
    check("post_rst_rdata", rd, 32'h4433_2211);
    check("post_rst_err", 32'(er), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
